// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges jump and stall requests into one hold code,
// stretches each jump into a flush window, and tracks stall statistics plus a watchdog.
module pipe_hold_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_rib_i,
    input  logic        hold_flag_clint_i,
    input  logic        jtag_halt_flag_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        flush_active_o,
    output logic [31:0] stall_cnt_o,
    output logic        stall_timeout_o
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT);
    localparam bit          USE_FLUSH    = (FLUSH_CYCLES > 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    logic any_hold;
    logic hold_id_term;
    logic holding;

    assign any_hold     = hold_flag_ex_i | hold_flag_rib_i | hold_flag_clint_i | jtag_halt_flag_i;
    assign hold_id_term = jump_flag_i | (state_q == ST_FLUSH) | hold_flag_ex_i
                        | hold_flag_clint_i | jtag_halt_flag_i;

    // Max of the hold terms: Hold_Id dominates Hold_Pc.
    always_comb begin
        hold_flag_o = HOLD_NONE;
        if (hold_id_term) begin
            hold_flag_o = HOLD_ID;
        end else if (hold_flag_rib_i) begin
            hold_flag_o = HOLD_PC;
        end
    end

    assign holding        = (hold_flag_o != HOLD_NONE);
    assign jump_flag_o    = jump_flag_i;
    assign jump_addr_o    = jump_flag_i ? jump_addr_i : 32'd0;
    assign flush_active_o = (state_q == ST_FLUSH);
    assign stall_cnt_o    = stall_cnt_q;
    assign stall_timeout_o = timeout_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (jump_flag_i) begin
                    if (USE_FLUSH) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (any_hold) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (jump_flag_i && USE_FLUSH) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (!any_hold) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (jump_flag_i) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = any_hold ? ST_STALL : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // Debug halts are intentional, so they never count toward the watchdog run.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (holding && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        run_cnt_d = run_cnt_q;
        if (!holding || jtag_halt_flag_i) begin
            run_cnt_d = 16'd0;
        end else if (run_cnt_q != TIMEOUT_W) begin
            run_cnt_d = run_cnt_q + 16'd1;
        end
        timeout_d = timeout_q | (run_cnt_d == TIMEOUT_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 3'd0;
            run_cnt_q   <= 16'd0;
            stall_cnt_q <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            run_cnt_q   <= run_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl; two instances share stimulus
// (FLUSH_CYCLES=3 and FLUSH_CYCLES=7, both with TIMEOUT=8).
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        hold_flag_ex_i = 1'b0;
    logic        hold_flag_rib_i = 1'b0;
    logic        hold_flag_clint_i = 1'b0;
    logic        jtag_halt_flag_i = 1'b0;

    logic [2:0]  hold3, hold7;
    logic        jf3, jf7;
    logic [31:0] ja3, ja7;
    logic        fa3, fa7;
    logic [31:0] sc3, sc7;
    logic        to3, to7;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hold_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
        .hold_flag_clint_i(hold_flag_clint_i), .jtag_halt_flag_i(jtag_halt_flag_i),
        .hold_flag_o(hold3), .jump_flag_o(jf3), .jump_addr_o(ja3),
        .flush_active_o(fa3), .stall_cnt_o(sc3), .stall_timeout_o(to3)
    );

    pipe_hold_ctrl #(.FLUSH_CYCLES(7), .TIMEOUT(8)) u_dut7 (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
        .hold_flag_clint_i(hold_flag_clint_i), .jtag_halt_flag_i(jtag_halt_flag_i),
        .hold_flag_o(hold7), .jump_flag_o(jf7), .jump_addr_o(ja7),
        .flush_active_o(fa7), .stall_cnt_o(sc7), .stall_timeout_o(to7)
    );

    task automatic clear_inputs();
        jump_flag_i = 1'b0; jump_addr_i = 32'd0;
        hold_flag_ex_i = 1'b0; hold_flag_rib_i = 1'b0;
        hold_flag_clint_i = 1'b0; jtag_halt_flag_i = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        vectors++;
        if (hold3 !== 3'd0 || sc3 !== 32'd0 || to3 !== 1'b0 || fa3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held: hold=%0d cnt=%0d to=%0b fa=%0b, want 0/0/0/0", hold3, sc3, to3, fa3);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (hold3 !== 3'd0 || sc3 !== 32'd0 || to3 !== 1'b0 || fa3 !== 1'b0
            || jf3 !== 1'b0 || ja3 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_release: hold=%0d cnt=%0d to=%0b fa=%0b jf=%0b ja=%h, want all 0",
                     hold3, sc3, to3, fa3, jf3, ja3);
        end
        $display("reset: hold=%0d cnt=%0d to=%0b fa=%0b", hold3, sc3, to3, fa3);
    endtask

    task automatic test_flush_window();
        logic [2:0] exp_hold [4] = '{3'd3, 3'd3, 3'd3, 3'd0};
        logic       exp_fa   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        pulse_reset();
        @(posedge clk); #1;
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
        @(negedge clk);
        vectors++;
        if (jf3 !== 1'b1 || ja3 !== 32'h100) begin
            miscompares++;
            $display("FAIL flush_jump_fwd: jf=%0b addr=%h, want 1/00000100", jf3, ja3);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                jump_flag_i = 1'b0; jump_addr_i = 32'hDEAD_BEEF;
                @(negedge clk);
            end
            vectors++;
            if (hold3 !== exp_hold[i] || fa3 !== exp_fa[i]) begin
                miscompares++;
                $display("FAIL flush_T+%0d: hold=%0d fa=%0b, want %0d/%0b", i, hold3, fa3, exp_hold[i], exp_fa[i]);
            end
            $display("flush T+%0d: hold=%0d fa=%0b", i, hold3, fa3);
        end
        vectors++;
        if (ja3 !== 32'd0 || sc3 !== 32'd3) begin
            miscompares++;
            $display("FAIL flush_after: addr=%h cnt=%0d, want 00000000/3", ja3, sc3);
        end
        jump_addr_i = 32'd0;
    endtask

    task automatic test_priority();
        pulse_reset();
        @(posedge clk); #1; hold_flag_rib_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (hold3 !== 3'd1) begin
            miscompares++;
            $display("FAIL prio_rib: hold=%0d, want 1", hold3);
        end
        $display("prio rib: hold=%0d", hold3);
        @(posedge clk); #1; hold_flag_ex_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (hold3 !== 3'd3) begin
            miscompares++;
            $display("FAIL prio_rib_ex: hold=%0d, want 3", hold3);
        end
        $display("prio rib+ex: hold=%0d", hold3);
        @(posedge clk); #1; hold_flag_ex_i = 1'b0; hold_flag_rib_i = 1'b0;
        #1;
        vectors++;
        if (hold3 !== 3'd0) begin
            miscompares++;
            $display("FAIL prio_drop: hold=%0d, want 0", hold3);
        end
        $display("prio drop: hold=%0d", hold3);
        @(posedge clk); #1; hold_flag_rib_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h40;
        @(negedge clk);
        vectors++;
        if (hold3 !== 3'd3 || jf3 !== 1'b1 || ja3 !== 32'h40) begin
            miscompares++;
            $display("FAIL prio_jump_rib: hold=%0d jf=%0b addr=%h, want 3/1/00000040", hold3, jf3, ja3);
        end
        $display("prio jump+rib: hold=%0d jf=%0b", hold3, jf3);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_hold [5] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
        logic       exp_fa   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            jump_flag_i = (i < 2); jump_addr_i = (i < 2) ? 32'h200 + 32'(i) * 4 : 32'd0;
            @(negedge clk);
            vectors++;
            if (hold3 !== exp_hold[i] || fa3 !== exp_fa[i]) begin
                miscompares++;
                $display("FAIL b2b_T+%0d: hold=%0d fa=%0b, want %0d/%0b", i, hold3, fa3, exp_hold[i], exp_fa[i]);
            end
            $display("b2b T+%0d: hold=%0d fa=%0b", i, hold3, fa3);
        end
    endtask

    task automatic test_watchdog();
        pulse_reset();
        @(posedge clk); #1; hold_flag_rib_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i >= 7) begin
                vectors++;
                if (to3 !== (i == 8)) begin
                    miscompares++;
                    $display("FAIL wdog_edge%0d: to=%0b, want %0b", i, to3, (i == 8));
                end
                $display("wdog edge %0d: to=%0b cnt=%0d", i, to3, sc3);
            end
        end
        hold_flag_rib_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (to3 !== 1'b1 || sc3 !== 32'd8) begin
            miscompares++;
            $display("FAIL wdog_sticky: to=%0b cnt=%0d, want 1/8", to3, sc3);
        end
        pulse_reset();
        @(posedge clk); #1; jtag_halt_flag_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (to3 !== 1'b0 || sc3 !== 32'd20 || hold3 !== 3'd3) begin
            miscompares++;
            $display("FAIL wdog_jtag: to=%0b cnt=%0d hold=%0d, want 0/20/3", to3, sc3, hold3);
        end
        $display("wdog jtag: to=%0b cnt=%0d", to3, sc3);
        clear_inputs();
    endtask

    task automatic test_reset_mid_flush();
        pulse_reset();
        @(posedge clk); #1; jump_flag_i = 1'b1; jump_addr_i = 32'h300;
        @(posedge clk); #1; clear_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (hold7 !== 3'd3 || fa7 !== 1'b1 || sc7 !== 32'd2) begin
            miscompares++;
            $display("FAIL midrst_pre: hold=%0d fa=%0b cnt=%0d, want 3/1/2", hold7, fa7, sc7);
        end
        #1; rst = 1'b0; #1;
        vectors++;
        if (hold7 !== 3'd0 || fa7 !== 1'b0 || sc7 !== 32'd0 || to7 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: hold=%0d fa=%0b cnt=%0d to=%0b, want 0/0/0/0", hold7, fa7, sc7, to7);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (hold7 !== 3'd0 || fa7 !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_after%0d: hold=%0d fa=%0b, want 0/0", i, hold7, fa7);
            end
            $display("midrst after %0d: hold=%0d fa=%0b cnt=%0d", i, hold7, fa7, sc7);
        end
    endtask

    initial begin
        test_reset();
        test_flush_window();
        test_priority();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Pipeline hold/flush controller for the 5-stage core. It merges jump requests from EX, multi-cycle stall requests from EX, the RIB bus, CLINT and JTAG halt into the single `hold_flag_o` code consumed by pc_reg and the stage registers (if_id and onward). It stretches each taken jump into a programmable multi-cycle flush window. It also keeps a saturating stall-cycle performance counter and a sticky stall-timeout watchdog.

## Interface

Parameters:
- `FLUSH_CYCLES`, default 1: cycles `hold_flag_o` is forced to at least `Hold_Id` per taken jump, including the jump cycle; legal range 1..7.
- `TIMEOUT`, default 1023: consecutive non-debug hold cycles that trip the watchdog; legal range 1..65535.

Ports:
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `jump_flag_i`, in, 1: EX requests a PC redirect this cycle.
- `jump_addr_i`, in, 32: redirect target.
- `hold_flag_ex_i`, in, 1: EX multi-cycle op (div/mul) busy.
- `hold_flag_rib_i`, in, 1: bus arbiter has taken the bus from the core.
- `hold_flag_clint_i`, in, 1: CLINT is performing interrupt entry/exit.
- `jtag_halt_flag_i`, in, 1: debug halt request.
- `hold_flag_o`, out, 3: hold code to the pipeline (`Hold_None`=0, `Hold_Pc`=1, `Hold_If`=2, `Hold_Id`=3).
- `jump_flag_o`, out, 1: redirect to pc_reg.
- `jump_addr_o`, out, 32: redirect target to pc_reg.
- `flush_active_o`, out, 1: high while in the FLUSH state.
- `stall_cnt_o`, out, 32: total cycles with `hold_flag_o != Hold_None`.
- `stall_timeout_o`, out, 1: sticky watchdog flag.

## Operation

State machine, state register reset to IDLE:
- **IDLE → FLUSH**: on `jump_flag_i` when `FLUSH_CYCLES > 1`.
- **IDLE → STALL**: on any of ex/rib/clint/jtag with no jump.
- **STALL → FLUSH**: on a jump, under the same `FLUSH_CYCLES > 1` rule as IDLE.
- **STALL → IDLE**: when all hold inputs are low.
- **FLUSH**: the counter `flush_cnt` is loaded with `FLUSH_CYCLES-1` at the end of the jump cycle and decrements every cycle.
  - At 1→0: go to STALL if any hold input is high, else IDLE.
  - A new `jump_flag_i` while in FLUSH reloads `flush_cnt` to `FLUSH_CYCLES-1`.

Hold merge: `hold_flag_o` is the numeric maximum of the terms below.
- `Hold_Id` if `jump_flag_i`, state FLUSH, `hold_flag_ex_i`, `hold_flag_clint_i` or `jtag_halt_flag_i`.
- `Hold_Pc` if `hold_flag_rib_i`.
- `Hold_None` otherwise.

Jump path:
- `jump_flag_o = jump_flag_i`, `jump_addr_o = jump_addr_i`.
- Combinational, so pc_reg redirects at the end of the jump cycle.
- `jump_addr_o` is forced to 0 when `jump_flag_i` is low.

Stall counter:
- `stall_cnt_o` increments on every edge where `hold_flag_o != Hold_None`.
- Saturates at 32'hFFFF_FFFF.

Watchdog:
- Run counter `run_cnt`, 16 bits, increments while `hold_flag_o != Hold_None` and `jtag_halt_flag_i` is low.
- It clears on any cycle with `hold_flag_o == Hold_None` or with `jtag_halt_flag_i` high.
- When `run_cnt` reaches `TIMEOUT`, `stall_timeout_o` sets and stays set until reset.
- `run_cnt` saturates at `TIMEOUT`.

## Timing

Reset (`rst` low, asynchronous):
- State goes to IDLE; `flush_cnt`, `run_cnt`, `stall_cnt_o` and `stall_timeout_o` go to 0.
- Combinational outputs follow their inputs with the state in IDLE.
- With all inputs low: `hold_flag_o = Hold_None`, `jump_flag_o = 0`, `jump_addr_o = 0`, `flush_active_o = 0`.

Latency and the jump window:
- `hold_flag_o`, `jump_flag_o` and `jump_addr_o` have zero-cycle latency from their inputs.
- A jump in cycle T holds `Hold_Id` in T..T+FLUSH_CYCLES-1.
- `flush_active_o` is high in T+1..T+FLUSH_CYCLES-1.

Simultaneous events:
- Jump together with `hold_flag_rib_i` gives `Hold_Id`, because max wins.
- The jump is still forwarded, and pc_reg gives the redirect priority over the hold.

Reset mid-FLUSH or mid-STALL: the controller returns to IDLE immediately, with no residual hold in the next cycle.

The `stall_cnt_o` increment and the watchdog set use the `hold_flag_o` value of the same cycle, registered at that cycle's edge.

## Test plan

- **Reset**: release `rst` with all inputs low → `hold_flag_o=0`, `stall_cnt_o=0`, `stall_timeout_o=0`, `flush_active_o=0`.
- **Flush window**: `FLUSH_CYCLES=3`, one-cycle jump to 0x0000_0100 at T → `jump_flag_o=1` with `jump_addr_o=0x100` at T, `hold_flag_o=3` for T..T+2, `flush_active_o=1` for T+1..T+2, `stall_cnt_o=3` afterwards.
- **Priority**: `hold_flag_rib_i=1` alone → `hold_flag_o=1`; then add `hold_flag_ex_i=1` → `hold_flag_o=3`; drop both → `hold_flag_o=0` the same cycle.
- **Back-to-back jumps**: `FLUSH_CYCLES=3`, jumps at T and T+1 → `Hold_Id` through T+3 (reload), with state IDLE at T+4.
- **Watchdog**: `TIMEOUT=8`, `hold_flag_rib_i` high for 8 cycles → `stall_timeout_o` rises after the 8th edge and stays 1 after the hold drops. Repeating with `jtag_halt_flag_i` high for 20 cycles → flag stays 0.
- **Reset mid-operation**: assert `rst` during the FLUSH of a `FLUSH_CYCLES=7` jump → outputs and counters return to the reset values asynchronously, and there is no `Hold_Id` after release.
